// File: rtl/ram1_uart_bus_ctrl_if.sv
// CPU-side request/acknowledge bundle for the Ram1/UART bus controller.
// The CPU (master) issues one word request; the controller (slave) answers with ack/rdata.
interface ram1_uart_bus_ctrl_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;
  logic        busy;

  modport master (output req, we, addr, wdata, input rdata, ack, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ack, busy);
endinterface

// File: rtl/ram1_uart_bus_ctrl.sv
// Ram1 SRAM / UART bus controller: runs one CPU word access at a time over the shared
// Ram1 data bus, using the SRAM strobes or the UART rdn/wrn handshake depending on address.
module ram1_uart_bus_ctrl #(
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
  parameter int unsigned RAM_WAIT       = 1
) (
  input  logic                       Clk0,
  input  logic                       Rst,
  ram1_uart_bus_ctrl_if.slave        bus,
  output logic                       Ram1_EN,
  output logic                       Ram1_OE,
  output logic                       Ram1_WE,
  output logic [17:0]                Ram1_address,
  inout  wire  [15:0]                Ram1_data,
  output logic                       rdn,
  output logic                       wrn,
  input  logic                       data_ready,
  input  logic                       tbre,
  input  logic                       tsre
);

  localparam logic [2:0] WAIT_LAST = 3'(RAM_WAIT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RAM_RD,
    S_RAM_WS,
    S_RAM_WP,
    S_RAM_WH,
    S_U_RWAIT,
    S_U_RD,
    S_U_WS,
    S_U_WP,
    S_U_TBRE,
    S_U_TSRE,
    S_STAT,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;

  logic        drive_en;
  logic [15:0] drive_val;

  always_ff @(posedge Clk0) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // The request direction is folded into the first state, so only addr/wdata are latched.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          if (bus.addr == UART_DATA_ADDR)      state_d = bus.we ? S_U_WS : S_U_RWAIT;
          else if (bus.addr == UART_STAT_ADDR) state_d = bus.we ? S_DONE : S_STAT;
          else                                 state_d = bus.we ? S_RAM_WS : S_RAM_RD;
        end
      end
      S_RAM_RD: begin
        if (cnt_q == WAIT_LAST) begin
          rdata_d = Ram1_data;
          state_d = S_DONE;
        end
      end
      S_RAM_WS:  state_d = S_RAM_WP;
      S_RAM_WP:  if (cnt_q == WAIT_LAST) state_d = S_RAM_WH;
      S_RAM_WH:  state_d = S_DONE;
      S_U_RWAIT: if (data_ready) state_d = S_U_RD;
      S_U_RD: begin
        if (cnt_q == 3'd1) begin
          rdata_d = {8'h00, Ram1_data[7:0]};
          state_d = S_DONE;
        end
      end
      S_U_WS:    state_d = S_U_WP;
      S_U_WP:    state_d = S_U_TBRE;
      S_U_TBRE:  if (tbre) state_d = S_U_TSRE;
      S_U_TSRE:  if (tsre) state_d = S_DONE;
      S_STAT: begin
        rdata_d = {14'b0, data_ready, tbre & tsre};
        state_d = S_DONE;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    // Dwell counter restarts on every state change; multi-cycle states compare against it.
    cnt_d = (state_d == state_q) ? cnt_q + 3'd1 : '0;
  end

  always_comb begin
    Ram1_EN   = 1'b1;
    Ram1_OE   = 1'b1;
    Ram1_WE   = 1'b1;
    rdn       = 1'b1;
    wrn       = 1'b1;
    bus.ack   = 1'b0;
    bus.busy  = (state_q != S_IDLE);
    drive_en  = 1'b0;
    drive_val = wdata_q;
    case (state_q)
      S_RAM_RD: begin
        Ram1_EN = 1'b0;
        Ram1_OE = 1'b0;
      end
      S_RAM_WS, S_RAM_WH: begin
        Ram1_EN  = 1'b0;
        drive_en = 1'b1;
      end
      S_RAM_WP: begin
        Ram1_EN  = 1'b0;
        Ram1_WE  = 1'b0;
        drive_en = 1'b1;
      end
      S_U_RD:   rdn = 1'b0;
      S_U_WS: begin
        drive_en  = 1'b1;
        drive_val = {8'h00, wdata_q[7:0]};
      end
      S_U_WP: begin
        wrn       = 1'b0;
        drive_en  = 1'b1;
        drive_val = {8'h00, wdata_q[7:0]};
      end
      S_DONE:   bus.ack = 1'b1;
      default:  ;
    endcase
  end

  assign bus.rdata    = rdata_q;
  assign Ram1_address = {2'b00, addr_q};
  assign Ram1_data    = drive_en ? drive_val : 'z;

endmodule

// File: tb/tb_ram1_uart_bus_ctrl.sv
// Self-checking bench for ram1_uart_bus_ctrl: SRAM/UART device models on the shared bus,
// a table of directed accesses, hand sequences for waits/reset, and randomized traffic.
module tb_ram1_uart_bus_ctrl;
  localparam int unsigned RAM_WAIT = 1;
  localparam logic [15:0] UDATA = 16'hBF00;
  localparam logic [15:0] USTAT = 16'hBF01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram1_uart_bus_ctrl_if cpu();
  logic        ram1_en, ram1_oe, ram1_we, rdn, wrn;
  logic        data_ready, tbre, tsre;
  logic [17:0] ram1_addr;
  wire  [15:0] ram1_data;
  logic        tb_drv;
  logic [15:0] tb_val;
  assign ram1_data = tb_drv ? tb_val : 16'hzzzz;

  ram1_uart_bus_ctrl #(
    .UART_DATA_ADDR(UDATA),
    .UART_STAT_ADDR(USTAT),
    .RAM_WAIT(RAM_WAIT)
  ) dut (
    .Clk0(clk),
    .Rst(rst_n),
    .bus(cpu.slave),
    .Ram1_EN(ram1_en),
    .Ram1_OE(ram1_oe),
    .Ram1_WE(ram1_we),
    .Ram1_address(ram1_addr),
    .Ram1_data(ram1_data),
    .rdn(rdn),
    .wrn(wrn),
    .data_ready(data_ready),
    .tbre(tbre),
    .tsre(tsre)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [15:0] mem_init(int i);
    return (i == 16) ? 16'h1234 : (16'(i * 257) ^ 16'h5555);
  endfunction

  // Device-side models: SRAM array and UART receive byte
  logic [15:0] dev_mem [256];
  logic        mem_ready = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        probe = 1'b0;
  logic [15:0] cur_wdata = 16'h0000;
  logic        in_uwr = 1'b0;

  always_comb begin
    tb_drv = 1'b0;
    tb_val = 16'h0000;
    if (probe) begin
      tb_drv = 1'b1;
      tb_val = 16'hA5C3;
    end else if (!ram1_en && !ram1_oe) begin
      tb_drv = 1'b1;
      tb_val = dev_mem[ram1_addr[7:0]];
    end else if (!rdn) begin
      tb_drv = 1'b1;
      tb_val = {8'hC3, rx_byte};
    end
  end

  typedef struct {
    int we_low; int oe_low; int en_low; int wrn_low; int rdn_low;
    int rdn_early; int ack; int wph; int wbus_bad; int tsre_bad;
  } snap_t;

  snap_t       mon = '{default: 0};
  logic [15:0] tx_word = 16'h0000;
  logic [17:0] last_wr_addr = '0;

  always @(negedge clk) begin
    if (!rst_n && !mem_ready) begin
      for (int i = 0; i < 256; i++) dev_mem[i] = mem_init(i);
      mem_ready = 1'b1;
    end
    if (!ram1_we) begin
      mon.we_low++;
      dev_mem[ram1_addr[7:0]] = ram1_data;
      last_wr_addr = ram1_addr;
    end
    if (!ram1_oe) mon.oe_low++;
    if (!ram1_en) mon.en_low++;
    if (!ram1_en && ram1_oe) begin
      mon.wph++;
      if (ram1_data !== cur_wdata) mon.wbus_bad++;
    end
    if (!wrn) begin
      mon.wrn_low++;
      tx_word = ram1_data;
    end
    if (!rdn) begin
      mon.rdn_low++;
      if (!data_ready) mon.rdn_early++;
    end
    if (cpu.ack) begin
      mon.ack++;
      if (in_uwr && !tsre) mon.tsre_bad++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One CPU access; lat = clock edge (counted from the accept edge) at which ack is seen high
  task automatic do_txn(input logic w, input logic [15:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output int lat);
    int n;
    @(negedge clk);
    cpu.req = 1'b1; cpu.we = w; cpu.addr = a; cpu.wdata = d;
    cur_wdata = d;
    @(posedge clk);
    #1 cpu.req = 1'b0;
    n = 0; lat = -1; rd = 16'h0000;
    while (lat < 0 && n < 300) begin
      @(negedge clk);
      if (cpu.ack) begin
        lat = n + 1;
        rd  = cpu.rdata;
      end else begin
        @(posedge clk);
        n++;
      end
    end
    if (lat < 0) begin
      chk("ack_timeout", 32'd0, 32'd1);
    end else begin
      chk("busy_at_ack", 32'(cpu.busy), 32'd1);
      @(negedge clk);
      chk("ack_one_cycle", 32'(cpu.ack), 32'd0);
      chk("busy_after_ack", 32'(cpu.busy), 32'd0);
    end
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        dr, tb, ts;
    logic [15:0] exp_rdata;
    int          exp_lat;
    int          exp_we_low;
    int          exp_oe_low;
  } vec_t;

  vec_t        vecs [10];
  logic [15:0] ref_mem [256];
  logic [15:0] exp_last;
  logic [15:0] rd, a, wd;
  int          lat, n, k, d, t, s;
  snap_t       s0;
  logic        r_dr, r_tb, r_ts;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    cpu.req = 1'b0; cpu.we = 1'b0; cpu.addr = '0; cpu.wdata = '0;
    data_ready = 1'b0; tbre = 1'b1; tsre = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(i);

    //            we    addr      wdata     dr    tb    ts    rdata     lat we oe
    vecs[0] = '{1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1234, 3, 0, 2};
    vecs[1] = '{1'b1, 16'h0020, 16'hBEEF, 1'b0, 1'b1, 1'b1, 16'h1234, 5, 2, 0};
    vecs[2] = '{1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hBEEF, 3, 0, 2};
    vecs[3] = '{1'b0, USTAT,    16'h0000, 1'b1, 1'b1, 1'b0, 16'h0002, 2, 0, 0};
    vecs[4] = '{1'b1, USTAT,    16'hFFFF, 1'b1, 1'b1, 1'b1, 16'h0002, 1, 0, 0};
    vecs[5] = '{1'b0, 16'h00FF, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hAAAA, 3, 0, 2};
    vecs[6] = '{1'b1, 16'hBF02, 16'h0102, 1'b0, 1'b1, 1'b1, 16'hAAAA, 5, 2, 0};
    vecs[7] = '{1'b0, 16'hBF02, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0102, 3, 0, 2};
    vecs[8] = '{1'b0, USTAT,    16'h0000, 1'b0, 1'b1, 1'b1, 16'h0001, 2, 0, 0};
    vecs[9] = '{1'b0, USTAT,    16'h0000, 1'b1, 1'b0, 1'b1, 16'h0002, 2, 0, 0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en", 32'(ram1_en), 32'd1);
    chk("rst_oe", 32'(ram1_oe), 32'd1);
    chk("rst_we", 32'(ram1_we), 32'd1);
    chk("rst_rdn_wrn", 32'({rdn, wrn}), 32'd3);
    chk("rst_ack_busy", 32'({cpu.ack, cpu.busy}), 32'd0);
    chk("rst_rdata", 32'(cpu.rdata), 32'd0);
    probe = 1'b1;
    #1 chk("rst_bus_released", 32'(ram1_data), 32'hA5C3);
    probe = 1'b0;
    rst_n = 1'b1;
    exp_last = 16'h0000;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      data_ready = vecs[i].dr; tbre = vecs[i].tb; tsre = vecs[i].ts;
      s0 = mon;
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
      chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_we_low", i), 32'(mon.we_low - s0.we_low), 32'(vecs[i].exp_we_low));
      chk($sformatf("vec%0d_oe_low", i), 32'(mon.oe_low - s0.oe_low), 32'(vecs[i].exp_oe_low));
      if (vecs[i].we && vecs[i].addr != USTAT) begin
        ref_mem[vecs[i].addr[7:0]] = vecs[i].wdata;
        chk($sformatf("vec%0d_addr", i), 32'(last_wr_addr), 32'({2'b00, vecs[i].addr}));
        chk($sformatf("vec%0d_wbus", i), 32'(mon.wph - s0.wph), 32'(RAM_WAIT + 3));
        chk($sformatf("vec%0d_wbus_val", i), 32'(mon.wbus_bad - s0.wbus_bad), 32'd0);
      end
      exp_last = vecs[i].exp_rdata;
    end
    data_ready = 1'b0; tbre = 1'b1; tsre = 1'b1;

    // UART write 0x41: tbre low 5 cycles, then tsre low 3 more
    tbre = 1'b0; tsre = 1'b0; in_uwr = 1'b1;
    s0 = mon;
    fork
      do_txn(1'b1, UDATA, 16'h0041, rd, lat);
      begin
        repeat (5) @(negedge clk);
        tbre = 1'b1;
        repeat (3) @(negedge clk);
        tsre = 1'b1;
      end
    join
    in_uwr = 1'b0;
    chk("uwr_wrn_pulse", 32'(mon.wrn_low - s0.wrn_low), 32'd1);
    chk("uwr_en_high", 32'(mon.en_low - s0.en_low), 32'd0);
    chk("uwr_byte", 32'(tx_word), 32'h0041);
    chk("uwr_ack_after_tsre", 32'(mon.tsre_bad - s0.tsre_bad), 32'd0);
    chk("uwr_rdata_kept", 32'(rd), 32'(exp_last));

    // UART read: data_ready low 4 cycles, byte 0x5A
    rx_byte = 8'h5A;
    s0 = mon;
    fork
      do_txn(1'b0, UDATA, 16'h0000, rd, lat);
      begin
        repeat (4) @(negedge clk);
        data_ready = 1'b1;
      end
    join
    data_ready = 1'b0;
    chk("urd_rdata", 32'(rd), 32'h005A);
    chk("urd_rdn_low", 32'(mon.rdn_low - s0.rdn_low), 32'd2);
    chk("urd_rdn_wait", 32'(mon.rdn_early - s0.rdn_early), 32'd0);
    chk("urd_en_high", 32'(mon.en_low - s0.en_low), 32'd0);
    exp_last = 16'h005A;

    // Second req while busy must be ignored
    data_ready = 1'b0; tbre = 1'b1; tsre = 1'b1;
    s0 = mon;
    @(negedge clk);
    cpu.req = 1'b1; cpu.we = 1'b0; cpu.addr = USTAT;
    @(posedge clk);
    #1 cpu.we = 1'b1; cpu.addr = 16'h0033; cpu.wdata = 16'h9999;
    @(posedge clk);
    #1 cpu.req = 1'b0;
    repeat (8) @(negedge clk);
    chk("busy_req_one_ack", 32'(mon.ack - s0.ack), 32'd1);
    chk("busy_req_no_write", 32'(mon.we_low - s0.we_low), 32'd0);
    chk("busy_req_rdata", 32'(cpu.rdata), 32'h0001);
    exp_last = 16'h0001;

    // Reset during the write pulse aborts with no ack
    s0 = mon;
    @(negedge clk);
    cpu.req = 1'b1; cpu.we = 1'b1; cpu.addr = 16'h0077; cpu.wdata = 16'hDEAD;
    cur_wdata = 16'hDEAD;
    @(posedge clk);
    #1 cpu.req = 1'b0;
    n = 0;
    @(negedge clk);
    while (ram1_we && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_wp", 32'(ram1_we), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_we", 32'(ram1_we), 32'd1);
    chk("abort_en", 32'(ram1_en), 32'd1);
    chk("abort_busy", 32'(cpu.busy), 32'd0);
    chk("abort_ack", 32'(cpu.ack), 32'd0);
    probe = 1'b1;
    #1 chk("abort_bus_released", 32'(ram1_data), 32'hA5C3);
    probe = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_ack", 32'(mon.ack - s0.ack), 32'd0);
    exp_last = 16'h0000;
    do_txn(1'b1, 16'h0077, 16'h1357, rd, lat);
    ref_mem[8'h77] = 16'h1357;
    chk("after_abort_wr_lat", 32'(lat), 32'd5);
    do_txn(1'b0, 16'h0077, 16'h0000, rd, lat);
    chk("after_abort_rd", 32'(rd), 32'h1357);
    exp_last = 16'h1357;

    // Randomized traffic against the reference model
    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, 5);
      s0 = mon;
      case (k)
        0: begin
          a = 16'($urandom);
          if (a == UDATA || a == USTAT) a = 16'h0100;
          wd = 16'($urandom);
          ref_mem[a[7:0]] = wd;
          do_txn(1'b1, a, wd, rd, lat);
          chk("rnd_ramwr_lat", 32'(lat), 32'd5);
          chk("rnd_ramwr_we_low", 32'(mon.we_low - s0.we_low), 32'(RAM_WAIT + 1));
          chk("rnd_ramwr_bus", 32'(mon.wbus_bad - s0.wbus_bad), 32'd0);
          chk("rnd_ramwr_addr", 32'(last_wr_addr), 32'({2'b00, a}));
          chk("rnd_ramwr_rdata", 32'(rd), 32'(exp_last));
        end
        1: begin
          a = 16'($urandom);
          if (a == UDATA || a == USTAT) a = 16'h0200;
          do_txn(1'b0, a, 16'h0000, rd, lat);
          chk("rnd_ramrd_lat", 32'(lat), 32'd3);
          chk("rnd_ramrd_oe_low", 32'(mon.oe_low - s0.oe_low), 32'(RAM_WAIT + 1));
          chk("rnd_ramrd_rdata", 32'(rd), 32'(ref_mem[a[7:0]]));
          exp_last = ref_mem[a[7:0]];
        end
        2: begin
          rx_byte = 8'($urandom);
          d = $urandom_range(0, 5);
          fork
            do_txn(1'b0, UDATA, 16'h0000, rd, lat);
            begin
              repeat (d) @(negedge clk);
              data_ready = 1'b1;
            end
          join
          data_ready = 1'b0;
          chk("rnd_urd_rdata", 32'(rd), 32'({8'h00, rx_byte}));
          chk("rnd_urd_rdn_low", 32'(mon.rdn_low - s0.rdn_low), 32'd2);
          chk("rnd_urd_wait", 32'(mon.rdn_early - s0.rdn_early), 32'd0);
          chk("rnd_urd_en", 32'(mon.en_low - s0.en_low), 32'd0);
          exp_last = {8'h00, rx_byte};
        end
        3: begin
          wd = 16'($urandom);
          t = $urandom_range(0, 6);
          s = $urandom_range(0, 4);
          tbre = 1'b0; tsre = 1'b0; in_uwr = 1'b1;
          fork
            do_txn(1'b1, UDATA, wd, rd, lat);
            begin
              repeat (t) @(negedge clk);
              tbre = 1'b1;
              repeat (s) @(negedge clk);
              tsre = 1'b1;
            end
          join
          in_uwr = 1'b0;
          chk("rnd_uwr_wrn", 32'(mon.wrn_low - s0.wrn_low), 32'd1);
          chk("rnd_uwr_byte", 32'(tx_word), 32'({8'h00, wd[7:0]}));
          chk("rnd_uwr_tsre", 32'(mon.tsre_bad - s0.tsre_bad), 32'd0);
          chk("rnd_uwr_en", 32'(mon.en_low - s0.en_low), 32'd0);
          chk("rnd_uwr_rdata", 32'(rd), 32'(exp_last));
        end
        4: begin
          r_dr = 1'($urandom); r_tb = 1'($urandom); r_ts = 1'($urandom);
          data_ready = r_dr; tbre = r_tb; tsre = r_ts;
          do_txn(1'b0, USTAT, 16'h0000, rd, lat);
          chk("rnd_stat_lat", 32'(lat), 32'd2);
          chk("rnd_stat_rdata", 32'(rd), 32'({14'b0, r_dr, r_tb & r_ts}));
          exp_last = {14'b0, r_dr, r_tb & r_ts};
          data_ready = 1'b0; tbre = 1'b1; tsre = 1'b1;
        end
        default: begin
          do_txn(1'b1, USTAT, 16'($urandom), rd, lat);
          chk("rnd_statwr_lat", 32'(lat), 32'd1);
          chk("rnd_statwr_quiet", 32'(mon.en_low - s0.en_low + mon.wrn_low - s0.wrn_low), 32'd0);
          chk("rnd_statwr_rdata", 32'(rd), 32'(exp_last));
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
